// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-port arbiter in front of one registered LSL/LSR/ASR/ROR shift unit
//
// Purpose:
//   One shift unit is shared between two requesters: port 0 (execute stage)
//   and port 1 (multicycle/coprocessor sequencer). Each request port uses a
//   valid/ready handshake. Contention is resolved round-robin. The shifted
//   result is captured in a one-entry output register, and a tag records
//   which port was served. Latency is one cycle. Throughput is one result per
//   cycle when the consumer keeps rsp_ready high.
//
// Build option:
//   SHARB_FIXED_PRIO_EN - when defined, port 0 always wins contention and
//   port 1 may starve. When undefined (default), arbitration is round-robin.
//   The handshake, latency and shift semantics are the same in both builds.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   req0_valid  in   port 0 request valid
//   req0_ready  out  port 0 request accepted this cycle
//   req0_sh     in   port 0 control: [AMT_W+1:2] amount, [1:0] type
//   req0_data   in   port 0 operand
//   req1_valid  in   port 1 request valid
//   req1_ready  out  port 1 request accepted this cycle
//   req1_sh     in   port 1 control, same encoding as req0_sh
//   req1_data   in   port 1 operand
//   rsp_valid   out  result register holds a valid result
//   rsp_ready   in   consumer takes the result
//   rsp_data    out  shifted result
//   rsp_id      out  port that issued the result
//
// Shift types: 00 LSL, 01 LSR (zero fill), 10 ASR (sign fill), 11 ROR.
// An amount of 0 returns the operand unchanged for every type.

module shift_arbiter #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AMT_W+1:0]  req0_sh,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AMT_W+1:0]  req1_sh,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  logic              can_accept;
  logic              grant;
  logic              accept;
  logic [AMT_W+1:0]  sel_sh;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [1:0]        sel_type;
  logic [DATA_W-1:0] ror_result;
  logic [DATA_W-1:0] shift_result;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  // A new result may be latched when the output register is empty, or when
  // it is being drained on this same edge. This allows back-to-back results
  // with no bubble.
  assign can_accept = !rsp_valid || rsp_ready;

`ifdef SHARB_FIXED_PRIO_EN
  // Fixed priority: port 0 wins whenever it is valid.
  always_comb begin
    grant = 1'b0;
    if (!req0_valid && req1_valid) begin
      grant = 1'b1;
    end
  end
`else
  // Round-robin: last_grant records the most recently accepted port. Its
  // reset value of 1 lets port 0 win the first contention.
  logic last_grant;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // last_grant changes only on an accept. Under backpressure no accept
  // happens, so the pending winner is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  // Ready is qualified by the port's own valid, so it is never offered to an
  // idle port. Ready is also forced low while reset is held.
  assign req0_ready = !reset && can_accept && req0_valid && (grant == 1'b0);
  assign req1_ready = !reset && can_accept && req1_valid && (grant == 1'b1);

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // ---------------------------------------------------------------------
  // Operand select and shift unit
  // ---------------------------------------------------------------------
  assign sel_sh   = grant ? req1_sh   : req0_sh;
  assign sel_data = grant ? req1_data : req0_data;
  assign sel_amt  = sel_sh[AMT_W+1:2];
  assign sel_type = sel_sh[1:0];

  // Rotate by right-shifting the operand concatenated with itself. The shift
  // amount stays below DATA_W, so no shift by DATA_W is ever formed.
  // Amount 0 returns the operand unchanged.
  assign ror_result = DATA_W'({sel_data, sel_data} >> sel_amt);

  always_comb begin
    shift_result = sel_data;
    unique case (sel_type)
      SH_LSL:  shift_result = sel_data << sel_amt;
      SH_LSR:  shift_result = sel_data >> sel_amt;
      SH_ASR:  shift_result = $signed(sel_data) >>> sel_amt;
      default: shift_result = ror_result;
    endcase
  end

  // ---------------------------------------------------------------------
  // One-entry output register
  // ---------------------------------------------------------------------
  // Under backpressure (valid and not ready) neither branch changes data or
  // id, so both stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shift_result;
      rsp_id    <= grant;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [AMT_W+1:0]  req0_sh;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_ready;
  logic [AMT_W+1:0]  req1_sh;
  logic [DATA_W-1:0] req1_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DATA_W-1:0] exp_data;
  logic              exp_id;
  logic              exp_grant;

  shift_arbiter #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sh(req0_sh), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sh(req1_sh), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester rule: a pending request keeps valid and payload until ready.
  logic              p0_v, p0_r, p1_v, p1_r;
  logic [AMT_W+1:0]  p0_sh, p1_sh;
  logic [DATA_W-1:0] p0_d, p1_d;

  always @(posedge clk) begin
    if (!reset && p0_v && !p0_r)
      check_eq("hold0", {req0_valid, req0_sh, req0_data}, {1'b1, p0_sh, p0_d});
    if (!reset && p1_v && !p1_r)
      check_eq("hold1", {req1_valid, req1_sh, req1_data}, {1'b1, p1_sh, p1_d});
    p0_v <= req0_valid; p0_r <= req0_ready; p0_sh <= req0_sh; p0_d <= req0_data;
    p1_v <= req1_valid; p1_r <= req1_ready; p1_sh <= req1_sh; p1_d <= req1_data;
  end

  // Issue one request on a single port with the other port idle.
  task automatic send(input int port, input logic [4:0] amt, input logic [1:0] typ,
                      input logic [31:0] d, input logic [31:0] exp, input string tag);
    if (port == 0) begin
      req0_valid = 1'b1; req0_sh = {amt, typ}; req0_data = d;
    end else begin
      req1_valid = 1'b1; req1_sh = {amt, typ}; req1_data = d;
    end
    #1;
    check_eq({tag, "_rdy"}, (port == 0) ? req0_ready : req1_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq({tag, "_vld"},  rsp_valid, 1);
    check_eq({tag, "_data"}, rsp_data, exp);
    check_eq({tag, "_id"},   rsp_id, port[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_sh = '0; req0_data = '0;
    req1_valid = 1'b0; req1_sh = '0; req1_data = '0;
    tick();
    tick();
    // Reset state, and ready held low during reset
    check_eq("rst_vld",  rsp_valid, 0);
    check_eq("rst_data", rsp_data, 0);
    check_eq("rst_id",   rsp_id, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("rst_rdy0", req0_ready, 0);
    check_eq("rst_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Single op on port 0
    send(0, 5'd4, 2'b10, 32'h8000_0001, 32'hF800_0000, "single");

    // All shift types on port 1, plus amount boundaries
    send(1, 5'd8,  2'b00, 32'h1234_5678, 32'h3456_7800, "lsl8");
    send(1, 5'd8,  2'b01, 32'h1234_5678, 32'h0012_3456, "lsr8");
    send(1, 5'd8,  2'b10, 32'h1234_5678, 32'h0012_3456, "asr8");
    send(1, 5'd8,  2'b11, 32'h1234_5678, 32'h7812_3456, "ror8");
    send(1, 5'd0,  2'b11, 32'h1234_5678, 32'h1234_5678, "ror0");
    send(1, 5'd0,  2'b10, 32'h8765_4321, 32'h8765_4321, "asr0");
    send(1, 5'd31, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "asr31");
    send(1, 5'd31, 2'b01, 32'h8000_0000, 32'h0000_0001, "lsr31");
    send(1, 5'd31, 2'b00, 32'h0000_0001, 32'h8000_0000, "lsl31");
    send(1, 5'd31, 2'b11, 32'h0000_0001, 32'h0000_0002, "ror31");

    // Contention: both ports continuously valid
    req0_valid = 1'b1; req0_sh = {5'd4, 2'b00}; req0_data = 32'h0000_00F0;
    req1_valid = 1'b1; req1_sh = {5'd4, 2'b01}; req1_data = 32'h0F00_0000;
    for (int i = 0; i < 4; i++) begin
`ifdef SHARB_FIXED_PRIO_EN
      exp_grant = 1'b0;
`else
      exp_grant = (i % 2) == 1;
`endif
      exp_id   = exp_grant;
      exp_data = exp_grant ? 32'h00F0_0000 : 32'h0000_0F00;
      #1;
      check_eq("cont_rdy0", req0_ready, !exp_grant);
      check_eq("cont_rdy1", req1_ready, exp_grant);
      tick();
      check_eq("cont_vld",  rsp_valid, 1);
      check_eq("cont_id",   rsp_id, exp_id);
      check_eq("cont_data", rsp_data, exp_data);
    end

    // Backpressure with both ports still valid
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_rdy0", req0_ready, 0);
      check_eq("bp_rdy1", req1_ready, 0);
      tick();
      check_eq("bp_vld",  rsp_valid, 1);
      check_eq("bp_data", rsp_data, exp_data);
      check_eq("bp_id",   rsp_id, exp_id);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_rel_rdy0", req0_ready, 1);
    check_eq("bp_rel_rdy1", req1_ready, 0);
    tick();
    check_eq("bp_rel_id",   rsp_id, 0);
    check_eq("bp_rel_data", rsp_data, 32'h0000_0F00);
    req0_valid = 1'b0;
    #1;
    check_eq("bp_p1_rdy", req1_ready, 1);
    tick();
    check_eq("bp_p1_id",   rsp_id, 1);
    check_eq("bp_p1_data", rsp_data, 32'h00F0_0000);
    req1_valid = 1'b0;

    // Reset mid-operation with a stalled result
    send(0, 5'd1, 2'b00, 32'h0000_0001, 32'h0000_0002, "pre_rst");
    rsp_ready = 1'b0;
    tick();
    check_eq("stall_vld",  rsp_valid, 1);
    check_eq("stall_data", rsp_data, 32'h0000_0002);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_vld",  rsp_valid, 0);
    check_eq("mid_rst_data", rsp_data, 0);
    check_eq("mid_rst_id",   rsp_id, 0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_sh = {5'd1, 2'b00}; req0_data = 32'h0000_0003;
    req1_valid = 1'b1; req1_sh = {5'd1, 2'b01}; req1_data = 32'h0000_0008;
    #1;
    check_eq("post_rst_rdy0", req0_ready, 1);
    check_eq("post_rst_rdy1", req1_ready, 0);
    tick();
    check_eq("post_rst_id",   rsp_id, 0);
    check_eq("post_rst_data", rsp_data, 32'h0000_0006);
    req0_valid = 1'b0;
    tick();
    check_eq("post_rst_id1",   rsp_id, 1);
    check_eq("post_rst_data1", rsp_data, 32'h0000_0004);
    req1_valid = 1'b0;
    tick();
    check_eq("drain_vld", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
